if_fetch: RTL and testbench

Instruction-fetch stage directly upstream of ID. It owns the program counter and issues one word request at a time to the Icache. It supplies ID with the PC of the instruction currently returning from the Icache. It applies control-flow redirects from EX (taken branch) and ID (jal/jalr), and it holds fetch while the flow controller back-and-keeps the front end.

---
 rtl/if_fetch.sv | 126 ++++++++++++
 tb/tb_if_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage sitting directly upstream of ID.
//
// Owns the program counter and keeps at most one word request in flight to
// the Icache. It reports to ID the PC of the instruction whose data is
// returning, and applies redirects from EX (taken branch) and ID (jal/jalr).
// It also stops issuing new requests while the flow controller holds the
// front end.
//
// Ports:
//   clk               clock, all state updates on posedge
//   rst               synchronous active-high reset
//   if_Icache_req_o   fetch request valid
//   if_Icache_addr_o  fetch address, always word-aligned
//   Icache_gnt_i      request accepted this cycle (only meaningful with req)
//   Icache_rvalid_i   data for the outstanding request returns this cycle
//   ex_btype_taken_i  taken branch resolved in EX
//   ex_btype_pc_i     branch target
//   id_jump_flag_i    jal/jalr decoded in ID
//   id_jump_pc_i      jump target
//   fc_bk_if_i        back-and-keep: suppress new requests
//   ifid_pc_o         PC of the last granted request
//   if_inst_valid_o   returning data is valid (rvalid and not killed)
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_Icache_req_o,
  output logic [31:0] if_Icache_addr_o,
  input  logic        Icache_gnt_i,
  input  logic        Icache_rvalid_i,
  input  logic        ex_btype_taken_i,
  input  logic [31:0] ex_btype_pc_i,
  input  logic        id_jump_flag_i,
  input  logic [31:0] id_jump_pc_i,
  input  logic        fc_bk_if_i,
  output logic [31:0] ifid_pc_o,
  output logic        if_inst_valid_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        kill_q, kill_d;

  logic        redirect;
  logic [31:0] target_aligned;
  logic        grant;

  // EX holds the older instruction, so its branch wins over an ID jump.
  assign redirect       = ex_btype_taken_i | id_jump_flag_i;
  assign target_aligned = (ex_btype_taken_i ? ex_btype_pc_i : id_jump_pc_i) & 32'hFFFF_FFFC;

  // Request and address depend only on registered state and the hold input,
  // so there is no combinational path from gnt or rvalid back to the Icache.
  assign if_Icache_req_o  = (state_q == REQ) & ~fc_bk_if_i;
  assign if_Icache_addr_o = pc_q & 32'hFFFF_FFFC;
  assign grant            = if_Icache_req_o & Icache_gnt_i;

  // A return is dropped if its request was killed earlier, or if a redirect
  // arrives in the very cycle the data comes back.
  assign if_inst_valid_o = (state_q == WAIT) & Icache_rvalid_i & ~kill_q & ~redirect;

  assign ifid_pc_o = ifid_pc_q;

  // Next-state logic for the fetch FSM, PC, granted PC and kill flag.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ifid_pc_d = ifid_pc_q;
    kill_d    = kill_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (grant) begin
          state_d   = WAIT;
          ifid_pc_d = pc_q;
          pc_d      = pc_q + 32'd4;
          // A redirect in the grant cycle means this request is already stale.
          kill_d    = redirect;
        end
      end
      WAIT: begin
        if (Icache_rvalid_i) begin
          state_d = REQ;
          kill_d  = 1'b0;
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A redirect overrides any sequential +4 update.
    if (redirect) begin
      pc_d = target_aligned;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ifid_pc_q <= RESET_PC;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ifid_pc_q <= ifid_pc_d;
      kill_q    <= kill_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        if_Icache_req_o;
  logic [31:0] if_Icache_addr_o;
  logic        Icache_gnt_i;
  logic        Icache_rvalid_i;
  logic        ex_btype_taken_i;
  logic [31:0] ex_btype_pc_i;
  logic        id_jump_flag_i;
  logic [31:0] id_jump_pc_i;
  logic        fc_bk_if_i;
  logic [31:0] ifid_pc_o;
  logic        if_inst_valid_o;

  int tests_run;
  int tests_failed;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_Icache_req_o  (if_Icache_req_o),
    .if_Icache_addr_o (if_Icache_addr_o),
    .Icache_gnt_i     (Icache_gnt_i),
    .Icache_rvalid_i  (Icache_rvalid_i),
    .ex_btype_taken_i (ex_btype_taken_i),
    .ex_btype_pc_i    (ex_btype_pc_i),
    .id_jump_flag_i   (id_jump_flag_i),
    .id_jump_pc_i     (id_jump_pc_i),
    .fc_bk_if_i       (fc_bk_if_i),
    .ifid_pc_o        (ifid_pc_o),
    .if_inst_valid_o  (if_inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the fetch unit: the next PC, the PC handed to ID,
  // whether the post-reset dead cycle has elapsed, and a queue of in-flight
  // requests each tagged with whether it has been killed.
  logic [31:0] m_pc;
  logic [31:0] m_ifid;
  bit          m_known;
  bit          m_started;
  bit          m_pend[$];

  bit          m_redir;
  logic [31:0] m_tgt;
  bit          e_req;
  bit          e_valid;

  // Compare one observed value against its expectation and keep the tallies.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then wait for the
  // falling edge so outputs can be observed away from the active edge.
  task automatic applyStimulus(input logic r, input logic g, input logic rv,
                               input logic ex, input logic [31:0] expc,
                               input logic idj, input logic [31:0] idpc,
                               input logic bk);
    @(posedge clk);
    #1;
    rst              = r;
    Icache_gnt_i     = g;
    Icache_rvalid_i  = rv;
    ex_btype_taken_i = ex;
    ex_btype_pc_i    = expc;
    id_jump_flag_i   = idj;
    id_jump_pc_i     = idpc;
    fc_bk_if_i       = bk;
    @(negedge clk);
  endtask

  // Every falling edge: check DUT outputs against the model, then advance the
  // model by the clock edge that follows using the inputs held this cycle.
  always @(negedge clk) begin
    m_redir = (ex_btype_taken_i === 1'b1) || (id_jump_flag_i === 1'b1);
    m_tgt   = (ex_btype_taken_i === 1'b1) ? ex_btype_pc_i : id_jump_pc_i;
    e_req   = m_known && m_started && (m_pend.size() == 0) && (fc_bk_if_i !== 1'b1);
    e_valid = m_known && (m_pend.size() > 0) && (Icache_rvalid_i === 1'b1) && !m_pend[0] && !m_redir;

    if (m_known) begin
      checkOutput("model_req",   {31'd0, if_Icache_req_o}, {31'd0, e_req});
      checkOutput("model_valid", {31'd0, if_inst_valid_o}, {31'd0, e_valid});
      checkOutput("model_ifid",  ifid_pc_o, m_ifid);
      if (m_started && m_pend.size() == 0)
        checkOutput("model_addr", if_Icache_addr_o, m_pc);
    end

    if (rst === 1'b1) begin
      m_pc      = 32'h0000_0000;
      m_ifid    = 32'h0000_0000;
      m_started = 1'b0;
      m_known   = 1'b1;
      m_pend.delete();
    end else if (m_known) begin
      if (m_pend.size() > 0) begin
        if (Icache_rvalid_i === 1'b1) void'(m_pend.pop_front());
        else if (m_redir) m_pend[0] = 1'b1;
      end
      if (e_req && Icache_gnt_i === 1'b1) begin
        m_pend.push_back(m_redir);
        m_ifid = m_pc;
        m_pc   = m_pc + 32'd4;
      end
      if (m_redir) m_pc = m_tgt & 32'hFFFF_FFFC;
      m_started = 1'b1;
    end
  end

  initial begin
    rst = 1'b1; Icache_gnt_i = 1'b0; Icache_rvalid_i = 1'b0;
    ex_btype_taken_i = 1'b0; ex_btype_pc_i = 32'd0;
    id_jump_flag_i = 1'b0; id_jump_pc_i = 32'd0; fc_bk_if_i = 1'b0;
    tests_run = 0; tests_failed = 0;

    // Reset values.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_req",   {31'd0, if_Icache_req_o}, 32'd0);
    checkOutput("rst_valid", {31'd0, if_inst_valid_o}, 32'd0);
    checkOutput("rst_ifid",  ifid_pc_o, 32'h0);

    // Dead cycle, then sequential fetch with gnt tied high and rvalid one cycle later.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("dead_req", {31'd0, if_Icache_req_o}, 32'd0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("first_req",  {31'd0, if_Icache_req_o}, 32'd1);
    checkOutput("first_addr", if_Icache_addr_o, 32'h0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("ret0_valid", {31'd0, if_inst_valid_o}, 32'd1);
    checkOutput("ret0_ifid",  ifid_pc_o, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("addr4", if_Icache_addr_o, 32'h4);
    checkOutput("gap_valid", {31'd0, if_inst_valid_o}, 32'd0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("ret4_ifid", ifid_pc_o, 32'h4);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("addr8", if_Icache_addr_o, 32'h8);

    // Jump in WAIT one cycle before rvalid: that return is dropped.
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h103, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("killed_valid", {31'd0, if_inst_valid_o}, 32'd0);
    checkOutput("ret8_ifid",    ifid_pc_o, 32'h8);
    applyStimulus(0, 1, 0, 1, 32'h200, 1, 32'h300, 0);
    checkOutput("jump_addr", if_Icache_addr_o, 32'h100);

    // Branch and jump together with grant: granted return killed, EX wins.
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("gntkill_valid", {31'd0, if_inst_valid_o}, 32'd0);
    checkOutput("gntkill_ifid",  ifid_pc_o, 32'h100);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("ex_prio_addr", if_Icache_addr_o, 32'h200);

    // Back-and-keep for 5 cycles starting in WAIT.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("bk_req0", {31'd0, if_Icache_req_o}, 32'd0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1);
    checkOutput("bk_valid", {31'd0, if_inst_valid_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
      checkOutput("bk_req", {31'd0, if_Icache_req_o}, 32'd0);
      checkOutput("bk_ifid", ifid_pc_o, 32'h200);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("resume_addr", if_Icache_addr_o, 32'h204);

    // Delayed grant with a branch to 0x40 in the second waiting cycle.
    applyStimulus(0, 0, 0, 1, 32'h40, 0, 0, 0);
    checkOutput("held_addr", if_Icache_addr_o, 32'h204);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("switch_addr", if_Icache_addr_o, 32'h40);

    // Reset in WAIT, return arrives after release and is ignored.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pre_rst_ifid", ifid_pc_o, 32'h40);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("stale_valid", {31'd0, if_inst_valid_o}, 32'd0);
    checkOutput("stale_ifid",  ifid_pc_o, 32'h0);

    // Restart at RESET_PC, then wrap from 0xFFFF_FFFC to 0.
    applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0);
    checkOutput("restart_addr", if_Icache_addr_o, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("top_addr", if_Icache_addr_o, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("top_ifid", ifid_pc_o, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_addr", if_Icache_addr_o, 32'h0);

    // Randomized traffic; rvalid is only offered while a request is in flight.
    for (int n = 0; n < 4000; n++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    1'($urandom_range(0, 1)),
                    (m_pend.size() > 0) && ($urandom_range(0, 2) == 0),
                    $urandom_range(0, 11) == 0, $urandom(),
                    $urandom_range(0, 11) == 0, $urandom(),
                    $urandom_range(0, 4) == 0);
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
